// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, instruction-memory request and IF/ID register with branch/stall/flush.
// Define IFU_PERF_CNT_EN to add the FetchCount performance counter.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] Address,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PCPlus4,
    output logic        IF_Valid,
    output logic        Misaligned
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount
`endif
);
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] next_pc;
    logic        squash;
    logic        load;

    assign Address = pc;
    assign pc_plus = pc + PC_INC;
    // A redirect overrides a stall; the target is forced to word alignment.
    assign next_pc = BranchTaken ? {BranchTarget[31:2], 2'b00} : Stall ? pc : pc_plus;
    assign squash  = Flush | BranchTaken;
    assign load    = !squash && !Stall;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc             <= RESET_PC;
            IF_Instruction <= '0;
            IF_PCPlus4     <= '0;
            IF_Valid       <= 1'b0;
            Misaligned     <= 1'b0;
        end else begin
            pc         <= next_pc;
            Misaligned <= BranchTaken & |BranchTarget[1:0];
            if (squash) begin
                IF_Instruction <= '0;
                IF_Valid       <= 1'b0;
            end else if (load) begin
                IF_Instruction <= Instruction;
                IF_PCPlus4     <= pc_plus;
                IF_Valid       <= 1'b1;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) FetchCount <= '0;
        else if (load) FetchCount <= FetchCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus randomized run against a behavioural model.
// Memory model: mem[i] = i*3 over Address[8:2].
module tb_instruction_fetch_unit;
    logic        Clk = 0;
    logic        Reset = 0;
    logic        Stall = 0;
    logic        Flush = 0;
    logic        BranchTaken = 0;
    logic [31:0] BranchTarget = 0;
    logic [31:0] Instruction;
    logic [31:0] Address;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCPlus4;
    logic        IF_Valid;
    logic        Misaligned;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] FetchCount;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_ins, m_p4, m_cnt;
    logic        m_v, m_mis;

    instruction_fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Instruction(Instruction), .Address(Address),
        .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4),
        .IF_Valid(IF_Valid), .Misaligned(Misaligned)
`ifdef IFU_PERF_CNT_EN
        , .FetchCount(FetchCount)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a / 4 % 128) * 3;
    endfunction

    assign Instruction = mem_word(Address);

    // One clock: the model applies the fetch rules to the inputs present before the edge.
    task automatic tick();
        logic [31:0] pc, ins, p4, cnt;
        logic v, mis;
        pc = m_pc; ins = m_ins; p4 = m_p4; v = m_v; cnt = m_cnt;
        mis = BranchTaken && (BranchTarget % 4 != 0);
        if (BranchTaken) pc = BranchTarget - BranchTarget % 4;
        else if (!Stall) pc = m_pc + 4;
        if (Flush || BranchTaken) begin
            ins = 0; v = 0;
        end else if (!Stall) begin
            ins = mem_word(m_pc); p4 = m_pc + 4; v = 1; cnt = m_cnt + 1;
        end
        @(posedge Clk);
        #1;
        m_pc = pc; m_ins = ins; m_p4 = p4; m_v = v; m_mis = mis; m_cnt = cnt;
    endtask

    task automatic apply_reset();
        Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = 0;
        Reset = 1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 0;
        m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (Address !== 0 || IF_Instruction !== 0 || IF_PCPlus4 !== 0 || IF_Valid !== 0 || Misaligned !== 0) begin
            failures++;
            $display("FAIL reset: addr=%h ins=%h p4=%h v=%b mis=%b required all zero",
                     Address, IF_Instruction, IF_PCPlus4, IF_Valid, Misaligned);
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (FetchCount !== 0) begin
            failures++;
            $display("FAIL reset_count: got %0d required 0", FetchCount);
        end
`endif
    endtask

    task automatic test_sequential();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (IF_Instruction !== 32'(i * 3) || IF_PCPlus4 !== 32'(4 * i + 4) || IF_Valid !== 1'b1) begin
                failures++;
                $display("FAIL seq[%0d]: ins=%0d p4=%0d v=%b required ins=%0d p4=%0d v=1",
                         i, IF_Instruction, IF_PCPlus4, IF_Valid, i * 3, 4 * i + 4);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        repeat (3) tick();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Address !== 12 || IF_Instruction !== 6) begin
                failures++;
                $display("FAIL stall[%0d]: addr=%0d ins=%0d required addr=12 ins=6", i, Address, IF_Instruction);
            end
        end
        Stall = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (IF_Instruction !== 32'(9 + 3 * i)) begin
                failures++;
                $display("FAIL stall_release[%0d]: ins=%0d required %0d", i, IF_Instruction, 9 + 3 * i);
            end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        repeat (2) tick();
        BranchTaken = 1; BranchTarget = 40;
        tick();
        BranchTaken = 0;
        checks++;
        if (Address !== 40 || IF_Valid !== 0 || IF_Instruction !== 0 || Misaligned !== 0) begin
            failures++;
            $display("FAIL branch: addr=%0d v=%b ins=%0d mis=%b required 40 0 0 0",
                     Address, IF_Valid, IF_Instruction, Misaligned);
        end
        tick();
        checks++;
        if (IF_Instruction !== 30 || IF_Valid !== 1) begin
            failures++;
            $display("FAIL branch_target: ins=%0d v=%b required 30 1", IF_Instruction, IF_Valid);
        end
        BranchTaken = 1; BranchTarget = 22;
        tick();
        BranchTaken = 0;
        checks++;
        if (Misaligned !== 1 || Address !== 20) begin
            failures++;
            $display("FAIL misaligned: mis=%b addr=%0d required 1 20", Misaligned, Address);
        end
        tick();
        checks++;
        if (Misaligned !== 0 || IF_Instruction !== 15) begin
            failures++;
            $display("FAIL misaligned_after: mis=%b ins=%0d required 0 15", Misaligned, IF_Instruction);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        repeat (4) tick();
        Flush = 1;
        tick();
        Flush = 0;
        checks++;
        if (IF_Valid !== 0 || IF_Instruction !== 0 || Address !== 20 || IF_PCPlus4 !== 16) begin
            failures++;
            $display("FAIL flush: v=%b ins=%0d addr=%0d p4=%0d required 0 0 20 16",
                     IF_Valid, IF_Instruction, Address, IF_PCPlus4);
        end
        tick();
        checks++;
        if (IF_Instruction !== 15 || IF_Valid !== 1) begin
            failures++;
            $display("FAIL flush_after: ins=%0d v=%b required 15 1", IF_Instruction, IF_Valid);
        end
        Stall = 1; Flush = 1;
        tick();
        Stall = 0; Flush = 0;
        checks++;
        if (IF_Valid !== 0 || Address !== 24) begin
            failures++;
            $display("FAIL stall_flush: v=%b addr=%0d required 0 24", IF_Valid, Address);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        repeat (6) tick();
        #2;
        Reset = 1;
        #1;
        checks++;
        if (Address !== 0 || IF_Valid !== 0 || IF_Instruction !== 0 || IF_PCPlus4 !== 0) begin
            failures++;
            $display("FAIL async_reset: addr=%0d v=%b ins=%0d p4=%0d required all zero",
                     Address, IF_Valid, IF_Instruction, IF_PCPlus4);
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (FetchCount !== 0) begin
            failures++;
            $display("FAIL async_reset_count: got %0d required 0", FetchCount);
        end
`endif
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (IF_Instruction !== 32'(3 * i)) begin
                failures++;
                $display("FAIL restart[%0d]: ins=%0d required %0d", i, IF_Instruction, 3 * i);
            end
`ifdef IFU_PERF_CNT_EN
            checks++;
            if (FetchCount !== 32'(i + 1)) begin
                failures++;
                $display("FAIL restart_count[%0d]: got %0d required %0d", i, FetchCount, i + 1);
            end
`endif
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 5) == 0);
            BranchTaken = ($urandom_range(0, 6) == 0);
            BranchTarget = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            tick();
            checks++;
            if (Address !== m_pc || IF_Instruction !== m_ins || IF_PCPlus4 !== m_p4 ||
                IF_Valid !== m_v || Misaligned !== m_mis) begin
                failures++;
                $display("FAIL random[%0d]: addr=%h ins=%h p4=%h v=%b mis=%b required %h %h %h %b %b",
                         n, Address, IF_Instruction, IF_PCPlus4, IF_Valid, Misaligned,
                         m_pc, m_ins, m_p4, m_v, m_mis);
            end
`ifdef IFU_PERF_CNT_EN
            checks++;
            if (FetchCount !== m_cnt) begin
                failures++;
                $display("FAIL random_count[%0d]: got %0d required %0d", n, FetchCount, m_cnt);
            end
`endif
        end
        Stall = 0; Flush = 0; BranchTaken = 0;
    endtask

    task automatic test_wrap();
        apply_reset();
        BranchTaken = 1; BranchTarget = 32'hFFFF_FFFC;
        tick();
        BranchTaken = 0;
        tick();
        checks++;
        if (Address !== 0 || IF_PCPlus4 !== 0 || IF_Valid !== 1 || IF_Instruction !== 32'd381) begin
            failures++;
            $display("FAIL wrap: addr=%h p4=%h v=%b ins=%0d required 0 0 1 381",
                     Address, IF_PCPlus4, IF_Valid, IF_Instruction);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
